demux_1x2_stream_buf: RTL and testbench

- Registered, flow-controlled 1-to-2 demultiplexer stage that sits directly downstream of the combinational 1x2 demux select path.
- Routes each accepted input word to output channel O1 (sel=0) or O2 (sel=1).
- Each channel has its own FIFO so one stalled consumer never corrupts data for the other.
- Optional alternate mode ignores sel and ping-pongs words O1, O2, O1, ...

---
 rtl/demux_pkg.sv | 14 +
 rtl/demux_1x2_stream_buf_fifo.sv | 78 +++++++
 rtl/demux_1x2_stream_buf.sv | 86 ++++++++
 tb/tb_demux_1x2_stream_buf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared channel encoding and sizing helper for the 1x2 stream demux and its FIFOs.
package demux_pkg;

   typedef enum logic {
      CH_O1 = 1'b0,
      CH_O2 = 1'b1
   } ch_e;

   // Occupancy must represent 0..depth inclusive, hence one bit beyond the pointer width.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/demux_1x2_stream_buf_fifo.sv
// Synchronous FIFO with a registered head word; one instance per demux output channel.
module stream_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = count_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] head_q;
   logic [AW-1:0]    rd_next;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_next = rd_ptr + AW'(1);
   assign count   = cnt;
   assign head    = head_q;

   // Storage array carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_next;
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Head tracks the oldest word; with more than one entry the successor is already in mem,
   // with exactly one entry a simultaneous push supplies it directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
      end else if (pop_ok && cnt > CW'(1)) begin
         head_q <= mem[rd_next];
      end else if (push_ok && (empty || pop_ok)) begin
         head_q <= push_data;
      end
   end

endmodule

// File: rtl/demux_1x2_stream_buf.sv
// Registered 1-to-2 stream demux: routes by in_sel or ping-pongs in alternate mode, one FIFO per channel.
module demux_1x2_stream_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = count_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alt_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [WIDTH-1:0] in_data,
   output logic             o1_valid,
   input  logic             o1_ready,
   output logic [WIDTH-1:0] o1_data,
   output logic             o2_valid,
   input  logic             o2_ready,
   output logic [WIDTH-1:0] o2_data,
   output logic [CW-1:0]    o1_count,
   output logic [CW-1:0]    o2_count
);

   ch_e  toggle;
   ch_e  eff_sel;
   logic accept;
   logic full1;
   logic full2;
   logic empty1;
   logic empty2;
   logic push1;
   logic push2;

   assign eff_sel  = alt_mode ? toggle : ch_e'(in_sel);
   // No bypass: a pop on a full channel frees space only from the next cycle.
   assign in_ready = (eff_sel == CH_O2) ? ~full2 : ~full1;
   assign accept   = in_valid & in_ready;
   assign push1    = accept & (eff_sel == CH_O1);
   assign push2    = accept & (eff_sel == CH_O2);
   assign o1_valid = ~empty1;
   assign o2_valid = ~empty2;

   // Alternate-mode pointer only advances on an actual accept, so a blocked word keeps its target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toggle <= CH_O1;
      end else if (accept && alt_mode) begin
         toggle <= (toggle == CH_O1) ? CH_O2 : CH_O1;
      end
   end

   stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo1 (
      .clk       (clk),
      .rst       (rst),
      .push      (push1),
      .push_data (in_data),
      .pop       (o1_ready),
      .full      (full1),
      .empty     (empty1),
      .count     (o1_count),
      .head      (o1_data)
   );

   stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo2 (
      .clk       (clk),
      .rst       (rst),
      .push      (push2),
      .push_data (in_data),
      .pop       (o2_ready),
      .full      (full2),
      .empty     (empty2),
      .count     (o2_count),
      .head      (o2_data)
   );

endmodule

// File: tb/tb_demux_1x2_stream_buf.sv
// Directed and randomized bench for demux_1x2_stream_buf against a queue-based channel model.
module tb_demux_1x2_stream_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             alt_mode;
   logic             in_valid;
   logic             in_ready;
   logic             in_sel;
   logic [WIDTH-1:0] in_data;
   logic             o1_valid;
   logic             o1_ready;
   logic [WIDTH-1:0] o1_data;
   logic             o2_valid;
   logic             o2_ready;
   logic [WIDTH-1:0] o2_data;
   logic [CW-1:0]    o1_count;
   logic [CW-1:0]    o2_count;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: one queue per channel, the alternate target, and the last head seen.
   logic [WIDTH-1:0] q1[$];
   logic [WIDTH-1:0] q2[$];
   bit               tog;
   logic [WIDTH-1:0] last1;
   logic [WIDTH-1:0] last2;

   always #5 clk = ~clk;

   demux_1x2_stream_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .alt_mode (alt_mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sel   (in_sel),
      .in_data  (in_data),
      .o1_valid (o1_valid),
      .o1_ready (o1_ready),
      .o1_data  (o1_data),
      .o2_valid (o2_valid),
      .o2_ready (o2_ready),
      .o2_data  (o2_data),
      .o1_count (o1_count),
      .o2_count (o2_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      tog   = 1'b0;
      last1 = '0;
      last2 = '0;
   endtask

   function automatic bit target();
      return alt_mode ? tog : in_sel;
   endfunction

   function automatic bit model_ready();
      return target() ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
   endfunction

   task automatic check_outputs(input string tag);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
      chk({tag, ".o1_valid"}, 32'(o1_valid), 32'(q1.size() != 0));
      chk({tag, ".o2_valid"}, 32'(o2_valid), 32'(q2.size() != 0));
      chk({tag, ".o1_data"},  32'(o1_data),  32'((q1.size() != 0) ? q1[0] : last1));
      chk({tag, ".o2_data"},  32'(o2_data),  32'((q2.size() != 0) ? q2[0] : last2));
      chk({tag, ".o1_count"}, 32'(o1_count), 32'(q1.size()));
      chk({tag, ".o2_count"}, 32'(o2_count), 32'(q2.size()));
   endtask

   // Called at posedge+1 with inputs already driven: check mid-cycle, then advance model at the edge.
   task automatic step(input string tag);
      bit acc;
      bit tgt;
      bit p1;
      bit p2;
      #4;
      check_outputs(tag);
      tgt = target();
      acc = in_valid && model_ready();
      p1  = o1_ready && (q1.size() != 0);
      p2  = o2_ready && (q2.size() != 0);
      @(posedge clk);
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (acc) begin
         if (tgt) q2.push_back(in_data);
         else     q1.push_back(in_data);
         if (alt_mode) tog = ~tog;
      end
      if (q1.size() != 0) last1 = q1[0];
      if (q2.size() != 0) last2 = q2[0];
      #1;
   endtask

   task automatic drive(input bit v, input bit s, input logic [WIDTH-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      rst      = 1'b1;
      alt_mode = 1'b0;
      in_valid = 1'b0;
      in_sel   = 1'b0;
      in_data  = '0;
      o1_ready = 1'b0;
      o2_ready = 1'b0;
      model_reset();
      #2;
      check_outputs("reset");
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Routing by select with both consumers ready.
      o1_ready = 1'b1;
      o2_ready = 1'b1;
      drive(1, 0, 8'hA1); step("route_a1");
      drive(1, 1, 8'hB2); step("route_b2");
      chk("route.o1_data_latency", 32'(o1_data), 32'h0A1);
      drive(0, 0, 8'h00); step("route_idle0");
      step("route_idle1");

      // O1 stalled: four words fill it, the fifth is refused, O2 still accepts.
      o1_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 8'h50 + 8'(i));
         step("fill_o1");
      end
      chk("full.o1_count", 32'(o1_count), 32'(DEPTH));
      chk("full.in_ready_blocked", 32'(in_ready), 32'h0);
      drive(1, 1, 8'h77); step("full_other_ch");
      drive(0, 0, 8'h00);
      o1_ready = 1'b1;
      for (int i = 0; i < 6; i++) step("drain_o1");

      // Alternate mode ignores in_sel.
      alt_mode = 1'b1;
      o1_ready = 1'b0;
      o2_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 8'h10 + 8'(i));
         step("alt_push");
      end
      drive(0, 1, 8'h00);
      chk("alt.o1_head", 32'(o1_data), 32'h10);
      chk("alt.o2_head", 32'(o2_data), 32'h11);
      o1_ready = 1'b1;
      o2_ready = 1'b1;
      for (int i = 0; i < 4; i++) step("alt_drain");

      // O2 held at two entries while pushing and popping together across pointer wrap.
      alt_mode = 1'b0;
      o2_ready = 1'b0;
      drive(1, 1, 8'hC0); step("wrap_pre0");
      drive(1, 1, 8'hC1); step("wrap_pre1");
      o2_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 8'hC2 + 8'(i));
         step("wrap_pp");
      end
      chk("wrap.o2_count", 32'(o2_count), 32'h2);
      drive(0, 0, 8'h00);
      for (int i = 0; i < 3; i++) step("wrap_drain");

      // Fill both to three, then reset asynchronously mid-cycle.
      o1_ready = 1'b0;
      o2_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, i[0], 8'h30 + 8'(i));
         step("pre_rst");
      end
      drive(0, 0, 8'h00);
      chk("pre_rst.o1_count", 32'(o1_count), 32'h3);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst.o1_count", 32'(o1_count), 32'h0);
      chk("async_rst.o2_count", 32'(o2_count), 32'h0);
      chk("async_rst.o1_valid", 32'(o1_valid), 32'h0);
      chk("async_rst.o2_valid", 32'(o2_valid), 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      alt_mode = 1'b1;
      drive(1, 1, 8'hE0); step("post_rst_alt");
      drive(0, 1, 8'h00); step("post_rst_idle");
      chk("post_rst.o1_data", 32'(o1_data), 32'hE0);
      o1_ready = 1'b1;
      step("post_rst_drain");
      // Reset again so the alternate target is back at O1 for the blocking case.
      #2 rst = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // Alternate word blocked on a full O1 keeps its target until O1 drains one.
      alt_mode = 1'b0;
      o1_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 8'h60 + 8'(i));
         step("blk_fill");
      end
      alt_mode = 1'b1;
      drive(1, 1, 8'h6A);
      step("blk_wait0");
      step("blk_wait1");
      chk("blk.o1_count", 32'(o1_count), 32'(DEPTH));
      o1_ready = 1'b1;
      step("blk_pop");
      o1_ready = 1'b0;
      step("blk_accept");
      drive(1, 0, 8'h6B);
      step("blk_next_o2");
      drive(0, 0, 8'h00);
      chk("blk.o2_data", 32'(o2_data), 32'h6B);
      o1_ready = 1'b1;
      o2_ready = 1'b1;
      for (int i = 0; i < 6; i++) step("blk_drain");

      // Randomized traffic with mode changes between words.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) alt_mode = ~alt_mode;
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
         o1_ready = 1'($urandom_range(0, 2) != 0);
         o2_ready = 1'($urandom_range(0, 3) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
